// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
package seg7_pkg;

  typedef enum logic {
    SCAN,
    BLANK
  } state_t;

  // Active-high all-segments-off pattern; polarity is applied at the pins.
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} segment decoder.
module seg7_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with tear-free source capture.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int N_SRC        = 2,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 2,
  parameter int COMMON_ANODE = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_SRC*N_DIGITS*4-1:0]               src_data,
  input  logic [(N_SRC > 1 ? $clog2(N_SRC) : 1)-1:0] src_sel,
  input  logic [N_DIGITS-1:0]                       digit_en,
  output logic [6:0]                                seg,
  output logic [N_DIGITS-1:0]                       an,
  output logic                                      frame_done
);
  import seg7_pkg::*;

  localparam int WW = N_DIGITS * 4;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [N_DIGITS-1:0] AN_IDLE  = (COMMON_ANODE != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_IDLE = (COMMON_ANODE != 0) ? ~SEG_OFF : SEG_OFF;

  state_t              state, state_n;
  logic [PW-1:0]       presc, presc_n;
  logic [BW-1:0]       bcnt, bcnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [WW-1:0]       shadow, shadow_n, sel_word;
  logic [N_DIGITS-1:0] shen, shen_n, an_oh, an_act;
  logic [6:0]          seg_dec, seg_act;
  logic [3:0]          nib;
  logic                wrap;
`ifdef SEG7_LZB_EN
  logic [N_DIGITS-1:0] lzb, lzb_n, lzb_calc;
  logic                zrun;
`endif

  // Out-of-range selects fall back to source 0.
  always_comb begin
    sel_word = src_data[WW-1:0];
    for (int unsigned s = 1; s < N_SRC; s++) begin
      if (int'(src_sel) == int'(s)) sel_word = src_data[s*WW +: WW];
    end
  end

`ifdef SEG7_LZB_EN
  // Walk down from the most significant digit; digit 0 is never blanked.
  always_comb begin
    lzb_calc = '0;
    zrun     = 1'b1;
    for (int unsigned d = int'(N_DIGITS - 1); d >= 1; d--) begin
      zrun        = zrun & (sel_word[d*4 +: 4] == 4'h0);
      lzb_calc[d] = zrun;
    end
  end
`endif

  always_comb begin
    state_n = state;
    presc_n = presc;
    bcnt_n  = bcnt;
    idx_n   = idx;
    wrap    = 1'b0;
    unique case (state)
      SCAN: begin
        if (presc == PW'(REFRESH_DIV - 1)) begin
          state_n = BLANK;
          bcnt_n  = '0;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      BLANK: begin
        if (bcnt == BW'(BLANK_CYCLES - 1)) begin
          state_n = SCAN;
          presc_n = '0;
          wrap    = (idx == IW'(N_DIGITS - 1));
          idx_n   = wrap ? '0 : idx + 1'b1;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: state_n = BLANK;
    endcase
    shadow_n = wrap ? sel_word : shadow;
    shen_n   = wrap ? digit_en : shen;
`ifdef SEG7_LZB_EN
    lzb_n    = wrap ? lzb_calc : lzb;
`endif
  end

  // Outputs are derived from next-state so they align with the edge that enters it.
  assign nib = shadow_n[int'(idx_n)*4 +: 4];

  seg7_decode u_decode (
    .nib (nib),
    .seg (seg_dec)
  );

  always_comb begin
    an_oh        = '0;
    an_oh[idx_n] = 1'b1;
    an_act       = '0;
    seg_act      = SEG_OFF;
    if (state_n == SCAN) begin
`ifdef SEG7_LZB_EN
      an_act  = an_oh & shen_n & ~lzb_n;
`else
      an_act  = an_oh & shen_n;
`endif
      seg_act = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      presc      <= '0;
      bcnt       <= '0;
      idx        <= IW'(N_DIGITS - 1);
      shadow     <= '0;
      shen       <= '0;
      an         <= AN_IDLE;
      seg        <= SEG_IDLE;
      frame_done <= 1'b0;
`ifdef SEG7_LZB_EN
      lzb        <= '0;
`endif
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      bcnt       <= bcnt_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      shen       <= shen_n;
      an         <= (COMMON_ANODE != 0) ? ~an_act : an_act;
      seg        <= (COMMON_ANODE != 0) ? ~seg_act : seg_act;
      frame_done <= wrap;
`ifdef SEG7_LZB_EN
      lzb        <= lzb_n;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed frame-level checks for seg7_scan_mux (4 digits, 2 sources, common anode).
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int NS = 2;
  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_data;
  logic [0:0]  src_sel;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .N_DIGITS     (ND),
    .N_SRC        (NS),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .COMMON_ANODE (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .digit_en   (digit_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    string            name;
    logic [15:0]      s0;
    logic [15:0]      s1;
    logic             sel;
    logic [3:0]       en;
    logic [3:0][3:0]  an_e;   // expected pin value per digit during its SCAN
    logic [3:0][6:0]  seg_e;
  } frame_vec_t;

  frame_vec_t vecs[6];

  // Active-low segment codes for hex 0..F.
  logic [6:0] hexseg [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input frame_vec_t v);
    src_data = {v.s1, v.s0};
    src_sel  = v.sel;
    digit_en = v.en;
  endtask

  // Called one cycle before the wrap edge; ends at the same point of the next frame.
  task automatic run_frame(input frame_vec_t v);
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < RD; c++) begin
        tick();
        if (d == 0 && c == 0) begin
          src_data = $urandom;
          src_sel  = ~v.sel;
          digit_en = ~v.en;
        end
        check($sformatf("%s d%0d c%0d an", v.name, d, c), 32'(an), 32'(v.an_e[d]));
        check($sformatf("%s d%0d c%0d seg", v.name, d, c), 32'(seg), 32'(v.seg_e[d]));
        check($sformatf("%s d%0d c%0d frame_done", v.name, d, c), 32'(frame_done),
              (d == 0 && c == 0) ? 32'd1 : 32'd0);
      end
      tick();
      check($sformatf("%s d%0d blank an", v.name, d), 32'(an), 32'hF);
      check($sformatf("%s d%0d blank seg", v.name, d), 32'(seg), 32'h7F);
      check($sformatf("%s d%0d blank frame_done", v.name, d), 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    frame_vec_t v;

    hexseg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0] = '{"v1234", 16'h1234, 16'hABCD, 1'b0, 4'hF,
                {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{"vABCD_sel1", 16'h1234, 16'hABCD, 1'b1, 4'hF,
                {4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[2] = '{"ven0101", 16'h1234, 16'hABCD, 1'b0, 4'b0101,
                {4'hF, 4'hB, 4'hF, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}};
`ifdef SEG7_LZB_EN
    vecs[3] = '{"v00C0", 16'h00C0, 16'h5555, 1'b0, 4'hF,
                {4'hF, 4'hF, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h46, 7'h40}};
    vecs[5] = '{"v0000", 16'h0000, 16'hFFFF, 1'b0, 4'hF,
                {4'hF, 4'hF, 4'hF, 4'hE}, {7'h40, 7'h40, 7'h40, 7'h40}};
`else
    vecs[3] = '{"v00C0", 16'h00C0, 16'h5555, 1'b0, 4'hF,
                {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h46, 7'h40}};
    vecs[5] = '{"v0000", 16'h0000, 16'hFFFF, 1'b0, 4'hF,
                {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif
    vecs[4] = '{"vFE98", 16'hFE98, 16'h0000, 1'b0, 4'hF,
                {4'h7, 4'hB, 4'hD, 4'hE}, {7'h0E, 7'h06, 7'h10, 7'h00}};

    rst_n = 1'b0;
    apply(vecs[0]);
    repeat (3) tick();
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Each frame scrambles inputs after its first cycle; the next row restores them.
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      run_frame(vecs[i]);
    end

    // Reset during digit 2 SCAN, then restart from scratch.
    apply(vecs[0]);
    repeat (12) tick();
    check("pre-reset digit2 an", 32'(an), 32'hB);
    rst_n = 1'b0;
    tick();
    check("midscan reset an", 32'(an), 32'hF);
    check("midscan reset seg", 32'(seg), 32'h7F);
    check("midscan reset frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    apply(vecs[0]);
    run_frame(vecs[0]);

    for (int n = 0; n < 16; n++) begin
      v.name  = $sformatf("sweep%0h", n);
      v.s0    = {12'h000, 4'(n)};
      v.s1    = 16'h8888;
      v.sel   = 1'b0;
      v.en    = 4'b0001;
      v.an_e  = {4'hF, 4'hF, 4'hF, 4'hE};
      v.seg_e = {7'h40, 7'h40, 7'h40, hexseg[n]};
      apply(v);
      run_frame(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed N-digit seven-segment display driver with source selection. Selects one of N_SRC packed hex words (e.g. received word vs. corrected word from the error-correction path), latches it tear-free at frame boundaries and scans it digit by digit onto shared segment lines with per-digit anode strobes. Sits between the decode/correction datapath and the board display pins.

## Interface
- N_DIGITS, 4, number of display digits (≥1)
- N_SRC, 2, number of selectable source words (≥1)
- REFRESH_DIV, 27000, clk cycles a digit is lit per visit (≥2)
- BLANK_CYCLES, 2, all-off cycles between digits for ghost suppression (≥1)
- COMMON_ANODE, 1, 1: `an` and `seg` active-low; 0: active-high
- clk  input  1  single system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- src_data  input  N_SRC*N_DIGITS*4  packed sources; source s occupies bits [s*N_DIGITS*4 +: N_DIGITS*4]; digit d is nibble d of it (d=0 rightmost)
- src_sel  input  max(1,$clog2(N_SRC))  source index; values ≥ N_SRC select source 0
- digit_en  input  N_DIGITS  per-digit enable; 0 keeps that anode off
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per COMMON_ANODE
- an  output  N_DIGITS  anode strobes, polarity per COMMON_ANODE
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- FSM states: SCAN, BLANK.
- SCAN: prescaler counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 → BLANK, blank counter cleared.
- BLANK: blank counter counts 0..BLANK_CYCLES-1; at BLANK_CYCLES-1 → SCAN, prescaler cleared, digit index advances (N_DIGITS-1 wraps to 0).
- On wrap to 0: shadow word ← selected source, shadow enable ← digit_en, frame_done = 1 for that cycle. Input changes mid-frame never affect the current frame.
- SCAN output: an = one-hot(index) gated by shadow enable; seg = hex decode of shadow nibble[index]. BLANK output: an all inactive, seg all off.
- Hex decode (active-high, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. COMMON_ANODE=1 inverts seg and an.

## Timing
- All outputs registered; they change on the same edge as the state/index they reflect (computed from next-state).
- Reset (rst_n low at edge): state BLANK, blank counter 0, index N_DIGITS-1, shadow word 0, shadow enable 0, an all inactive, seg all off, frame_done 0. Reset mid-scan aborts immediately with the same values.
- After reset release: BLANK_CYCLES blank cycles, then index 0 in SCAN with freshly captured shadow, frame_done pulses on that edge.
- Digit period REFRESH_DIV+BLANK_CYCLES cycles; frame period N_DIGITS×that.
- N_DIGITS=1: index stays 0; every BLANK→SCAN transition is a wrap (capture + frame_done).
- src_sel change coincident with wrap edge: new value is captured.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. At capture, a blank mask is computed: from digit N_DIGITS-1 downward, zero nibbles preceding the first nonzero nibble are blanked (an inactive during their SCAN); digit 0 is never blanked. Registered with the shadow, same timing.
- Undefined: all enabled digits show their nibble, zeros included; no mask logic.

## Structure
- Package seg7_pkg: state enum (SCAN, BLANK), SEG_OFF constant, 16-entry hex-to-segment function/table.
- Sub-module seg7_decode: combinational 4-bit → 7-bit active-high decoder; polarity applied in seg7_scan_mux.

## Test plan
Bench params N_DIGITS=4, N_SRC=2, REFRESH_DIV=4, BLANK_CYCLES=1, COMMON_ANODE=1.
- Reset then release, src0=16'h1234, sel=0, en=4'hF -> 1 blank cycle, then an=1110 seg=~7'h66 (4) for 4 cycles, frame_done pulse at first SCAN edge; digits 3,2,1 follow with 1 blank cycle each.
- sel flipped 0→1 mid-frame, src1=16'hABCD -> current frame still shows 1234; next frame digit 0 seg=~7'h5E (d).
- en=4'b0101 -> an for digits 1,3 stays 1111 during their SCAN; seg still driven.
- src0=16'h00C0 with SEG7_LZB_EN -> digits 3,2 blanked, digit1 C=~7'h39, digit0 0=~7'h3F; without macro all four lit.
- rst_n low during digit 2 SCAN -> next edge an=1111, seg=7'h7F, frame_done=0; restart as in first scenario.
- Sweep all 16 nibbles on digit 0 -> seg matches decode table, including C≠E.
